controle_reproducao: RTL

CONTROLE_REPRODUCAO -- requirements
Module: controle_reproducao

---
 rtl/controle_pkg.sv | 11 +
 rtl/controle_reproducao_debounce_botao.sv | 51 +++++
 rtl/controle_reproducao.sv | 108 ++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared constants for the playback controller: FSM state encodings and the
// default debounce length (20 ms at 50 MHz).
package controle_pkg;

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] PLAYING = 2'b01;
   localparam logic [1:0] PAUSED  = 2'b10;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/controle_reproducao_debounce_botao.sv
// debounce_botao: 2-flop synchronizer, stability counter and press pulse for
// one active-low key. The press pulse is registered one cycle after the
// debounced level falls.
module debounce_botao
   import controle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_r;
   logic             db_r;
   logic             db_d_r;
   logic [CNT_W-1:0] cnt_r;
   logic             press_r;
   logic             mismatch_s;

   assign mismatch_s = sync_r[1] ^ db_r;
   assign press      = press_r;

   // Synchronize, count consecutive mismatch cycles, flip level, detect 1->0
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r  <= 2'b11;
         db_r    <= 1'b1;
         db_d_r  <= 1'b1;
         cnt_r   <= '0;
         press_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], btn};
         db_d_r  <= db_r;
         press_r <= db_d_r & ~db_r;
         if (!mismatch_s) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            db_r  <= sync_r[1];
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/controle_reproducao.sv
// Playback controller: debounced play/stop keys drive an IDLE/PLAYING(/PAUSED)
// FSM. Optional pause support is enabled by defining CONTROLE_PAUSA_EN.
module controle_reproducao
   import controle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 20
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Btn_play,
   input  logic       Btn_stop,
   input  logic       Song_end,
   output logic       Play_out,
   output logic       Stop_out,
   output logic [1:0] Estado
);

   logic       play_ev_s;
   logic       stop_ev_s;
   logic [1:0] estado_r;
   logic [1:0] estado_nxt_s;
   logic       stop_s;
   logic       play_out_r;
   logic       stop_out_r;

   debounce_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_play (
      .clk   (Clk),
      .reset (Reset),
      .btn   (Btn_play),
      .press (play_ev_s)
   );

   debounce_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_stop (
      .clk   (Clk),
      .reset (Reset),
      .btn   (Btn_stop),
      .press (stop_ev_s)
   );

   // Next-state and stop request; stop always wins over play
   always_comb begin
      estado_nxt_s = estado_r;
      stop_s       = 1'b0;
      case (estado_r)
         IDLE: begin
            if (stop_ev_s) begin
               stop_s = 1'b1;
            end else if (play_ev_s) begin
               estado_nxt_s = PLAYING;
            end else begin
               estado_nxt_s = IDLE;
            end
         end
         PLAYING: begin
            if (stop_ev_s || Song_end) begin
               estado_nxt_s = IDLE;
               stop_s       = 1'b1;
`ifdef CONTROLE_PAUSA_EN
            end else if (play_ev_s) begin
               estado_nxt_s = PAUSED;
`endif
            end else begin
               estado_nxt_s = PLAYING;
            end
         end
`ifdef CONTROLE_PAUSA_EN
         PAUSED: begin
            if (stop_ev_s) begin
               estado_nxt_s = IDLE;
               stop_s       = 1'b1;
            end else if (play_ev_s) begin
               estado_nxt_s = PLAYING;
            end else begin
               estado_nxt_s = PAUSED;
            end
         end
`endif
         default: begin
            estado_nxt_s = IDLE;
         end
      endcase
   end

   // State and registered outputs; Stop_out is masked so it can never repeat
   always_ff @(posedge Clk) begin
      if (Reset) begin
         estado_r   <= IDLE;
         play_out_r <= 1'b0;
         stop_out_r <= 1'b0;
      end else begin
         estado_r   <= estado_nxt_s;
         play_out_r <= (estado_nxt_s == PLAYING);
         stop_out_r <= stop_s & ~stop_out_r;
      end
   end

   assign Estado   = estado_r;
   assign Play_out = play_out_r;
   assign Stop_out = stop_out_r;

endmodule
